// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Shares one single-port, 1-cycle-latency video RAM between the VGA scanout
//   fetcher (strict priority, one word per cycle) and a req/ack writer port
//   that is served only in cycles the scanout leaves idle.
//
// Optional feature: define VRAM_ARB_STATS_EN to add a saturating 16-bit
//   conflict counter (conflict_cnt) with synchronous clear (conflict_clr).
//
// Ports
//   CLK, RESET_N            clock, asynchronous active-low reset
//   scan_req/scan_addr      scanout read request and address
//   scan_data/scan_valid    scanout read data, valid 2 cycles after request
//   wr_req/wr_we/wr_addr/wr_wdata   writer request, held until wr_ack
//   wr_ack/wr_rdata         writer completion pulse and read data
//   mem_addr/mem_wdata/mem_we/mem_rdata   BRAM port
//   conflict_cnt/conflict_clr   (VRAM_ARB_STATS_EN only) stall statistics
module vram_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic [DATA_W-1:0] scan_data,
  output logic              scan_valid,
  input  logic              wr_req,
  input  logic              wr_we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_wdata,
  output logic              wr_ack,
  output logic [DATA_W-1:0] wr_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0]       conflict_cnt,
  input  logic              conflict_clr
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WACK = 2'd1,
    S_RD1  = 2'd2,
    S_RACK = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          vld_q;
  logic [DATA_W-1:0]   scan_data_q;
  logic [DATA_W-1:0]   wr_rdata_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                wr_grant;

  // Writer is only considered in IDLE, so at most one transaction is in flight.
  assign wr_grant = (state_q == S_IDLE) && wr_req && !scan_req;

  // Grant mux. With no grant the address/data hold their last values so the
  // BRAM port does not toggle needlessly.
  always_comb begin
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_we    = 1'b0;
    if (scan_req) begin
      mem_addr = scan_addr;
    end else if (wr_grant) begin
      mem_addr  = wr_addr;
      mem_wdata = wr_wdata;
      // Gated with the reset pin so no write can slip through while in reset.
      mem_we    = wr_we & RESET_N;
    end
  end

  // Writer FSM next state and ack.
  always_comb begin
    state_d = state_q;
    wr_ack  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wr_grant) state_d = wr_we ? S_WACK : S_RD1;
      end
      S_WACK: begin
        wr_ack  = 1'b1;
        state_d = S_IDLE;
      end
      S_RD1: begin
        state_d = S_RACK;
      end
      S_RACK: begin
        wr_ack  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      vld_q       <= 2'b00;
      scan_data_q <= '0;
      wr_rdata_q  <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
      // vld_q[0]: BRAM output this cycle belongs to a scan grant from last cycle.
      vld_q   <= {vld_q[0], scan_req};
      if (vld_q[0]) scan_data_q <= mem_rdata;
      // RD1 is the cycle the BRAM presents the writer's read data.
      if (state_q == S_RD1) wr_rdata_q <= mem_rdata;
    end
  end

  assign scan_valid = vld_q[1];
  assign scan_data  = scan_data_q;
  assign wr_rdata   = wr_rdata_q;

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] conflict_q, conflict_d;

  // Counts cycles in which a pending writer request is blocked by scanout.
  always_comb begin
    conflict_d = conflict_q;
    if (conflict_clr) begin
      conflict_d = 16'd0;
    end else if ((state_q == S_IDLE) && wr_req && scan_req &&
                 (conflict_q != 16'hFFFF)) begin
      conflict_d = conflict_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) conflict_q <= 16'd0;
    else          conflict_q <= conflict_d;
  end

  assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: stimulus pushes expected responses
// (cycle and data) into queues, a negedge monitor pops and compares them.
module tb_vram_arbiter;

  localparam int AW = 13;
  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic          scan_req;
  logic [AW-1:0] scan_addr;
  logic [DW-1:0] scan_data;
  logic          scan_valid;
  logic          wr_req;
  logic          wr_we;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_wdata;
  logic          wr_ack;
  logic [DW-1:0] wr_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
`ifdef VRAM_ARB_STATS_EN
  logic [15:0]   conflict_cnt;
  logic          conflict_clr;
`endif

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .scan_req   (scan_req),
    .scan_addr  (scan_addr),
    .scan_data  (scan_data),
    .scan_valid (scan_valid),
    .wr_req     (wr_req),
    .wr_we      (wr_we),
    .wr_addr    (wr_addr),
    .wr_wdata   (wr_wdata),
    .wr_ack     (wr_ack),
    .wr_rdata   (wr_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
`ifdef VRAM_ARB_STATS_EN
    ,
    .conflict_cnt (conflict_cnt),
    .conflict_clr (conflict_clr)
`endif
  );

  always #5 CLK = ~CLK;

  // Synchronous BRAM model, 1-cycle read latency.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge CLK) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int          at;
    logic [7:0]  data;
    logic        chk_data;
  } exp_t;

  exp_t scan_q[$];
  exp_t wr_q[$];
  int   checks = 0;
  int   failures = 0;

  // Monitor: every strobe must match the oldest expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (RESET_N) begin
      if (scan_valid) begin
        checks++;
        if (scan_q.size() == 0) begin
          failures++;
          $display("FAIL scan_unexpected cyc=%0d data=%02h required=no scan_valid", cyc, scan_data);
        end else begin
          e = scan_q.pop_front();
          if (e.at != cyc || scan_data != e.data) begin
            failures++;
            $display("FAIL scan_data cyc=%0d data=%02h required cyc=%0d data=%02h",
                     cyc, scan_data, e.at, e.data);
          end
        end
      end
      if (wr_ack) begin
        checks++;
        if (wr_q.size() == 0) begin
          failures++;
          $display("FAIL wr_ack_unexpected cyc=%0d required=no wr_ack", cyc);
        end else begin
          e = wr_q.pop_front();
          if (e.at != cyc || (e.chk_data && wr_rdata != e.data)) begin
            failures++;
            $display("FAIL wr_ack cyc=%0d rdata=%02h required cyc=%0d rdata=%02h",
                     cyc, wr_rdata, e.at, e.data);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Writer transaction; 'stall' = cycles scanout will block the grant.
  task automatic wr_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] exp_rd, input int stall);
    exp_t e;
    bit   got = 0;
    wr_req = 1'b1; wr_we = we; wr_addr = a; wr_wdata = d;
    e.at = cyc + stall + (we ? 1 : 2);
    e.data = exp_rd;
    e.chk_data = !we;
    wr_q.push_back(e);
    for (int i = 0; i < 200 && !got; i++) begin
      tick();
      if (wr_ack) got = 1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL wr_timeout cyc=%0d actual=no ack required=ack", cyc);
    end else begin
      tick();
    end
    wr_req = 1'b0;
    $display("wr txn we=%0d addr=%0h wdata=%02h exp_rdata=%02h done cyc=%0d", we, a, d, exp_rd, cyc);
  endtask

  task automatic scan_burst(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      scan_req = 1'b1;
      scan_addr = AW'(i % 8);
      e.at = cyc + 2;
      e.data = 8'h10 + 8'(i % 8);
      e.chk_data = 1'b1;
      scan_q.push_back(e);
      tick();
    end
    scan_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
    RESET_N = 1'b0;
    scan_req = 0; scan_addr = 0; wr_req = 0; wr_we = 0; wr_addr = 0; wr_wdata = 0;
`ifdef VRAM_ARB_STATS_EN
    conflict_clr = 1'b0;
`endif

    // Reset with random inputs: outputs must stay zero.
    for (int i = 0; i < 5; i++) begin
      tick();
      scan_req = 1'($urandom); scan_addr = AW'($urandom);
      wr_req = 1'($urandom); wr_we = 1'b1; wr_addr = AW'($urandom) | 13'h1000;
      wr_wdata = DW'($urandom);
      @(negedge CLK);
      check("rst_outputs", {scan_valid, wr_ack, mem_we, scan_data, wr_rdata}, 0);
    end
    tick();
    scan_req = 0; wr_req = 0; wr_we = 0; wr_addr = 0; wr_wdata = 0;
    tick();
    RESET_N = 1'b1;
    $display("reset released cyc=%0d", cyc);
    repeat (4) tick();
    check("post_rst_outputs", {scan_valid, wr_ack, scan_data, wr_rdata}, 0);

    // Scanout burst of 8.
    scan_burst(8);
    repeat (4) tick();

    // Idle writer write then read.
    wr_txn(1'b1, 13'h100, 8'hA5, 8'h00, 0);
    wr_txn(1'b0, 13'h100, 8'h00, 8'hA5, 0);

    // Contention: 20 scan cycles while a write to address 5 waits.
    fork
      begin
        exp_t e;
        for (int i = 0; i < 20; i++) begin
          scan_req = 1'b1;
          scan_addr = AW'(i % 8);
          e.at = cyc + 2; e.data = 8'h10 + 8'(i % 8); e.chk_data = 1'b1;
          scan_q.push_back(e);
          @(negedge CLK);
          check("contention_no_we", mem_we, 0);
          tick();
        end
        scan_req = 1'b0;
        @(negedge CLK);
        check("contention_we", {mem_we, 3'b0, mem_addr, mem_wdata}, {1'b1, 3'b0, 13'h5, 8'h3C});
      end
      wr_txn(1'b1, 13'h5, 8'h3C, 8'h00, 20);
    join
`ifdef VRAM_ARB_STATS_EN
    check("conflict_20", conflict_cnt, 20);
`endif
    wr_txn(1'b0, 13'h5, 8'h00, 8'h3C, 0);
    repeat (4) tick();

    // Reset asserted while the read is in RD1.
    wr_req = 1'b1; wr_we = 1'b0; wr_addr = 13'h100;
    tick();
    RESET_N = 1'b0;
    wr_req = 1'b0;
    $display("reset asserted mid-read cyc=%0d", cyc);
    @(negedge CLK);
    check("midrst_no_ack", wr_ack, 0);
    repeat (2) tick();
    RESET_N = 1'b1;
    repeat (3) tick();
    wr_txn(1'b0, 13'h100, 8'h00, 8'hA5, 0);
    repeat (4) tick();

`ifdef VRAM_ARB_STATS_EN
    check("conflict_after_rst", conflict_cnt, 0);
    begin
      exp_t e;
      wr_req = 1'b1; wr_we = 1'b1; wr_addr = 13'h1FF; wr_wdata = 8'h77;
      for (int i = 0; i < 70000; i++) begin
        scan_req = 1'b1; scan_addr = 0;
        e.at = cyc + 2; e.data = 8'h10; e.chk_data = 1'b1;
        scan_q.push_back(e);
        tick();
      end
      scan_req = 1'b0; wr_req = 1'b0;
      @(negedge CLK);
      check("conflict_sat", conflict_cnt, 16'hFFFF);
      tick();
      conflict_clr = 1'b1;
      @(negedge CLK);
      check("conflict_clr_same", conflict_cnt, 16'hFFFF);
      tick();
      conflict_clr = 1'b0;
      @(negedge CLK);
      check("conflict_cleared", conflict_cnt, 0);
      repeat (4) tick();
    end
`endif

    check("scan_q_drained", scan_q.size(), 0);
    check("wr_q_drained", wr_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single-port video RAM block between the VGA scanout pixel fetcher and a general writer port, for example a UART or pattern loader. Scanout has strict priority because it carries a hard per-pixel deadline. The writer uses a req/ack handshake and is served in cycles the scanout leaves idle. The block sits between the VGA timing/pixel pipeline and the BRAM in `top`, all in the 16 MHz `CLK` domain.

## Interface
- `ADDR_W`, default 13: VRAM word address width.
- `DATA_W`, default 8: VRAM word width.

- `CLK`  in  1  system clock, 16 MHz.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `scan_req`  in  1  scanout read request, one word per cycle it is high.
- `scan_addr`  in  ADDR_W  scanout read address.
- `scan_data`  out  DATA_W  scanout read data.
- `scan_valid`  out  1  `scan_data` valid strobe.
- `wr_req`  in  1  writer request, held until `wr_ack`.
- `wr_we`  in  1  writer op: 1 = write, 0 = read.
- `wr_addr`  in  ADDR_W  writer address.
- `wr_wdata`  in  DATA_W  writer write data.
- `wr_ack`  out  1  one-cycle completion pulse.
- `wr_rdata`  out  DATA_W  writer read data, valid with `wr_ack` on reads.
- `mem_addr`  out  ADDR_W  VRAM address.
- `mem_wdata`  out  DATA_W  VRAM write data.
- `mem_we`  out  1  VRAM write enable.
- `mem_rdata`  in  DATA_W  VRAM read data. The BRAM is synchronous and has 1-cycle read latency.

## Operation
- Clock and reset: one clock, `CLK`. Reset is asynchronous and active-low on `RESET_N`.
- Grant is decided combinationally each cycle:
  - If `scan_req` = 1, scanout owns the memory. `mem_addr` = `scan_addr`, `mem_we` = 0.
  - Otherwise, if the writer FSM is in IDLE and `wr_req` = 1, the writer owns it. `mem_addr` = `wr_addr`, `mem_wdata` = `wr_wdata`, `mem_we` = `wr_we`.
  - Otherwise `mem_we` = 0 and `mem_addr` holds its last value; the memory is not enabled.
- Scanout read pipeline: a 2-stage valid shift register carries scan grants. In the second cycle after the grant, `scan_data` is the registered `mem_rdata` and `scan_valid` = 1.
- Writer FSM states are IDLE, WACK, RD1 and RACK.
  - IDLE → WACK on a granted write. `wr_ack` = 1 in WACK. WACK → IDLE.
  - IDLE → RD1 on a granted read. RD1 captures `mem_rdata` into `wr_rdata`. RD1 → RACK, where `wr_ack` = 1. RACK → IDLE.
  - IDLE stays IDLE if `wr_req` = 0 or `scan_req` = 1. The writer is stalled for as long as scanout requests.
- The writer keeps `wr_req`, `wr_we`, `wr_addr` and `wr_wdata` stable until `wr_ack`. It drops `wr_req` in the cycle after `wr_ack`, or keeps it high to start a new transaction.
- `wr_req` is ignored outside IDLE, so one writer transaction is in flight at most.
- `wr_rdata` holds its value until the next read completes.
- Reset values: `scan_data` = 0, `scan_valid` = 0, `wr_ack` = 0, `wr_rdata` = 0, FSM = IDLE, valid pipeline = 0.
- `mem_we` is forced to 0 while `RESET_N` = 0.
- Reset mid-transaction drops the transaction: no `wr_ack`, no `scan_valid`. After release, the writer must re-request.

## Timing
- Scanout latency: `scan_req` high in cycle N gives `scan_valid` high in cycle N+2. Throughput is one word per cycle with back-to-back requests.
- Writer write, uncontended: `wr_req` in cycle N commits the memory write at the end of cycle N; `wr_ack` is high in cycle N+1.
- Writer read, uncontended: `wr_req` in cycle N gives `wr_ack` and `wr_rdata` in cycle N+2.
- Under contention the grant cycle N is the first cycle with `scan_req` = 0; the latencies above count from that cycle.
- Simultaneous writer write and scanout read of the same address in a later cycle: scanout sees the new data, since the write commits first.
- A writer request arriving in a cycle where `scan_req` drops is granted in that same cycle.

## Configuration
- `VRAM_ARB_STATS_EN`: when defined, the block adds output `conflict_cnt` (16 bits) and input `conflict_clr` (1 bit).
  - `conflict_cnt` increments in every cycle with FSM = IDLE, `wr_req` = 1 and `scan_req` = 1.
  - It saturates at 0xFFFF.
  - `conflict_clr` = 1 clears it synchronously; clear wins over an increment in the same cycle.
  - Reset value is 0.
- When the macro is not defined, neither port nor the counter logic exists, and the block's behaviour is otherwise identical.

## Test plan
- Reset: hold `RESET_N` low with random inputs, then release. All outputs are 0, and `wr_ack` does not appear before a request is made.
- Scanout burst: scan addresses 0..7 on 8 consecutive cycles, with the memory preloaded so mem[i] = i+0x10. `scan_valid` is high for 8 cycles starting 2 cycles after the first request, and data is 0x10..0x17 in order.
- Idle writer: write 0xA5 to address 0x100, then read address 0x100. The write is acked one cycle after the request and the read is acked two cycles after the request, with `wr_rdata` = 0xA5.
- Contention: `scan_req` held high for 20 cycles while the writer writes 0x3C to address 5. No `mem_we` occurs during the scan window, the write commits in the first cycle after the window, and `wr_ack` follows one cycle later. With `VRAM_ARB_STATS_EN` defined, `conflict_cnt` = 20.
- Reset mid-read: assert reset in RD1. No `wr_ack` appears and the FSM is in IDLE after release. A re-issued read returns the correct data.
- Stats saturation (`VRAM_ARB_STATS_EN` defined): force 70000 conflict cycles, then pulse `conflict_clr`. The count holds at 0xFFFF, then reads 0 in the cycle after the clear.
